// File: rtl/io_port_agent.sv
// rtl/io_port_agent.sv - CPU I/O port agent: host->CPU in-FIFO, CPU->host out-FIFO, sticky errors.
// Optional stall FSM (stop_req to datapath) enabled by defining IO_PORT_STALL_EN.
module io_port_agent #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        host_wr_valid,
  input  logic [31:0] host_wr_data,
  output logic        host_wr_ready,
  output logic [31:0] in_port_data,
  output logic        in_port_avail,
  input  logic        in_port_strb,
  input  logic [31:0] out_port_data,
  input  logic        out_port_strb,
  output logic        host_rd_valid,
  output logic [31:0] host_rd_data,
  input  logic        host_rd_ready,
  output logic        err_underrun,
  output logic        err_overrun,
  input  logic        err_clr,
  output logic        stop_req
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   in_mem_q  [DEPTH];
  logic [31:0]   out_mem_q [DEPTH];

  logic [AW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          err_underrun_q, err_underrun_d;
  logic          err_overrun_q, err_overrun_d;

  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;
  logic underrun_set, overrun_set;

  // Status flags derive from registered occupancy only.
  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);

  assign host_wr_ready = ~in_full;
  assign in_port_avail = ~in_empty;
  assign host_rd_valid = ~out_empty;
  assign in_port_data  = in_empty  ? 32'h0 : in_mem_q[in_rd_ptr_q];
  assign host_rd_data  = out_empty ? 32'h0 : out_mem_q[out_rd_ptr_q];
  assign err_underrun  = err_underrun_q;
  assign err_overrun   = err_overrun_q;

  // A full in-FIFO refuses a push even with a same-cycle pop, because ready is registered-state based.
  assign in_push  = host_wr_valid & host_wr_ready;
  assign in_pop   = in_port_strb & in_port_avail;
  assign out_push = out_port_strb & ~out_full;
  assign out_pop  = host_rd_valid & host_rd_ready;

`ifdef IO_PORT_STALL_EN
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_WAIT_IN  = 2'd1;
  localparam logic [1:0] ST_WAIT_OUT = 2'd2;

  logic [1:0] state_q, state_d;
  logic       stop_req_q, stop_req_d;

  // With stalling, a blocked strobe is re-issued by the datapath, so nothing is ever flagged.
  assign underrun_set = 1'b0;
  assign overrun_set  = 1'b0;
  assign stop_req     = stop_req_q;

  // Stall FSM next state: an empty read takes priority over a full write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (in_port_strb && in_empty)       state_d = ST_WAIT_IN;
        else if (out_port_strb && out_full) state_d = ST_WAIT_OUT;
      end
      ST_WAIT_IN:  if (!in_empty) state_d = ST_RUN;
      ST_WAIT_OUT: if (!out_full) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    stop_req_d = (state_d != ST_RUN);
  end

  // Stall FSM state and registered stop request.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_RUN;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_req_q <= stop_req_d;
    end
  end
`else
  // Without stalling, empty reads and full writes are recorded in the sticky flags.
  assign underrun_set = in_port_strb & in_empty;
  assign overrun_set  = out_port_strb & out_full;
  assign stop_req     = 1'b0;
`endif

  // Pointer, occupancy and sticky-flag next state; err_clr beats a same-cycle set.
  always_comb begin
    in_wr_ptr_d    = in_wr_ptr_q  + AW'(in_push);
    in_rd_ptr_d    = in_rd_ptr_q  + AW'(in_pop);
    in_cnt_d       = in_cnt_q     + CW'(in_push) - CW'(in_pop);
    out_wr_ptr_d   = out_wr_ptr_q + AW'(out_push);
    out_rd_ptr_d   = out_rd_ptr_q + AW'(out_pop);
    out_cnt_d      = out_cnt_q    + CW'(out_push) - CW'(out_pop);
    err_underrun_d = err_underrun_q | underrun_set;
    err_overrun_d  = err_overrun_q  | overrun_set;
    if (err_clr) begin
      err_underrun_d = 1'b0;
      err_overrun_d  = 1'b0;
    end
  end

  // Control state registers; reset empties both FIFOs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      in_wr_ptr_q    <= '0;
      in_rd_ptr_q    <= '0;
      in_cnt_q       <= '0;
      out_wr_ptr_q   <= '0;
      out_rd_ptr_q   <= '0;
      out_cnt_q      <= '0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      in_wr_ptr_q    <= in_wr_ptr_d;
      in_rd_ptr_q    <= in_rd_ptr_d;
      in_cnt_q       <= in_cnt_d;
      out_wr_ptr_q   <= out_wr_ptr_d;
      out_rd_ptr_q   <= out_rd_ptr_d;
      out_cnt_q      <= out_cnt_d;
      err_underrun_q <= err_underrun_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  // Storage arrays are not reset; the empty flags mask stale contents.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_ptr_q]   <= host_wr_data;
    if (out_push) out_mem_q[out_wr_ptr_q] <= out_port_data;
  end

endmodule

// File: tb/tb_io_port_agent.sv
// tb/tb_io_port_agent.sv - self-checking bench for io_port_agent with a queue-based reference model.
module tb_io_port_agent;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        host_wr_valid;
  logic [31:0] host_wr_data;
  logic        host_wr_ready;
  logic [31:0] in_port_data;
  logic        in_port_avail;
  logic        in_port_strb;
  logic [31:0] out_port_data;
  logic        out_port_strb;
  logic        host_rd_valid;
  logic [31:0] host_rd_data;
  logic        host_rd_ready;
  logic        err_underrun;
  logic        err_overrun;
  logic        err_clr;
  logic        stop_req;

  int n_cmp = 0;
  int n_err = 0;

  io_port_agent #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .in_port_data(in_port_data), .in_port_avail(in_port_avail), .in_port_strb(in_port_strb),
    .out_port_data(out_port_data), .out_port_strb(out_port_strb),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ready(host_rd_ready),
    .err_underrun(err_underrun), .err_overrun(err_overrun), .err_clr(err_clr), .stop_req(stop_req)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_wr_valid = 1'b0; host_wr_data = '0; in_port_strb = 1'b0;
    out_port_data = '0; out_port_strb = 1'b0; host_rd_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); clr = 1'b0;
    @(negedge clk); clr = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (host_wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b want 1", host_wr_ready); end
    n_cmp++; if (in_port_avail !== 1'b0) begin n_err++; $display("FAIL rst_avail: got %b want 0", in_port_avail); end
    n_cmp++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid: got %b want 0", host_rd_valid); end
    host_wr_valid = 1'b1; host_wr_data = 32'hA5A5_0001;
    cycle();
    idle();
    n_cmp++; if (in_port_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL pre_rst_data: got %h want a5a50001", in_port_data); end
    #2 clr = 1'b0;
    #1;
    n_cmp++; if (in_port_avail !== 1'b0) begin n_err++; $display("FAIL async_rst_avail: got %b want 0", in_port_avail); end
    n_cmp++; if (in_port_data !== 32'h0) begin n_err++; $display("FAIL async_rst_data: got %h want 0", in_port_data); end
    n_cmp++; if (host_wr_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b want 1", host_wr_ready); end
    n_cmp++; if (host_rd_data !== 32'h0) begin n_err++; $display("FAIL async_rst_rd_data: got %h want 0", host_rd_data); end
    n_cmp++; if ({err_underrun, err_overrun, stop_req} !== 3'b000) begin n_err++; $display("FAIL async_rst_flags: got %b want 000", {err_underrun, err_overrun, stop_req}); end
    @(negedge clk); clr = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      host_wr_valid = 1'b1; host_wr_data = 32'h100 + i; cycle();
    end
    out_port_strb = 1'b1; out_port_data = 32'h55; cycle();
    do_reset();
    n_cmp++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_empty: got %b want 0", host_rd_valid); end
    host_wr_valid = 1'b1; host_wr_data = 32'h9; cycle(); idle();
    n_cmp++; if (in_port_data !== 32'h9) begin n_err++; $display("FAIL mid_rst_first_push: got %h want 9", in_port_data); end
    in_port_strb = 1'b1; cycle(); idle();
    n_cmp++; if (in_port_avail !== 1'b0) begin n_err++; $display("FAIL mid_rst_one_word: got %b want 0", in_port_avail); end
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      host_wr_valid = 1'b1; host_wr_data = i; cycle();
    end
    idle();
    n_cmp++; if (host_wr_ready !== 1'b0) begin n_err++; $display("FAIL order_full: got %b want 0", host_wr_ready); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (in_port_data !== 32'(i)) begin n_err++; $display("FAIL order_data%0d: got %h want %h", i, in_port_data, 32'(i)); end
      in_port_strb = 1'b1; cycle(); idle();
    end
    n_cmp++; if (in_port_data !== 32'h0) begin n_err++; $display("FAIL order_empty_data: got %h want 0", in_port_data); end
    n_cmp++; if (in_port_avail !== 1'b0) begin n_err++; $display("FAIL order_avail: got %b want 0", in_port_avail); end
    n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL order_no_underrun: got %b want 0", err_underrun); end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      host_wr_valid = 1'b1; host_wr_data = i; cycle();
    end
    host_wr_data = 32'd5; in_port_strb = 1'b1; cycle(); idle();
    n_cmp++; if (host_wr_ready !== 1'b1) begin n_err++; $display("FAIL bnd_occ3_ready: got %b want 1", host_wr_ready); end
    for (int i = 2; i <= 4; i++) begin
      n_cmp++; if (in_port_data !== 32'(i)) begin n_err++; $display("FAIL bnd_drain%0d: got %h want %h", i, in_port_data, 32'(i)); end
      in_port_strb = 1'b1; cycle(); idle();
    end
    n_cmp++; if (in_port_avail !== 1'b0) begin n_err++; $display("FAIL bnd_5_refused: got %b want 0", in_port_avail); end
    host_wr_valid = 1'b1; host_wr_data = 32'd7; in_port_strb = 1'b1; cycle(); idle();
    n_cmp++; if (in_port_data !== 32'd7) begin n_err++; $display("FAIL bnd_push7: got %h want 7", in_port_data); end
`ifdef IO_PORT_STALL_EN
    n_cmp++; if (stop_req !== 1'b1) begin n_err++; $display("FAIL bnd_stall: got %b want 1", stop_req); end
`else
    n_cmp++; if (err_underrun !== 1'b1) begin n_err++; $display("FAIL bnd_underrun: got %b want 1", err_underrun); end
`endif
    err_clr = 1'b1; in_port_strb = 1'b1; cycle(); idle();
    n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL bnd_err_clr: got %b want 0", err_underrun); end
  endtask

`ifdef IO_PORT_STALL_EN
  task automatic test_stall();
    do_reset();
    in_port_strb = 1'b1; cycle(); idle();
    n_cmp++; if (stop_req !== 1'b1) begin n_err++; $display("FAIL stall_set: got %b want 1", stop_req); end
    host_wr_valid = 1'b1; host_wr_data = 32'hDEAD_BEEF; cycle(); idle();
    cycle();
    n_cmp++; if (stop_req !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", stop_req); end
    n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL stall_no_flag: got %b want 0", err_underrun); end
    n_cmp++; if (in_port_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_reissue: got %h want deadbeef", in_port_data); end
    in_port_strb = 1'b1; cycle(); idle();
  endtask
`else
  task automatic test_out_path();
    do_reset();
    for (int i = 10; i <= 14; i++) begin
      out_port_strb = 1'b1; out_port_data = i; cycle();
    end
    idle();
    n_cmp++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL out_overrun: got %b want 1", err_overrun); end
    err_clr = 1'b1; cycle(); idle();
    n_cmp++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL out_err_clr: got %b want 0", err_overrun); end
    for (int i = 10; i <= 13; i++) begin
      n_cmp++; if (host_rd_data !== 32'(i)) begin n_err++; $display("FAIL out_drain%0d: got %h want %h", i, host_rd_data, 32'(i)); end
      host_rd_ready = 1'b1; cycle(); idle();
    end
    n_cmp++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL out_14_dropped: got %b want 0", host_rd_valid); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] mq_in[$];
    logic [31:0] mq_out[$];
    bit m_ur, m_or, ready, av, full, nonempty;
    do_reset();
    m_ur = 0; m_or = 0;
    for (int c = 0; c < 400; c++) begin
      host_wr_valid = ($urandom_range(0, 99) < 55);
      host_wr_data  = $urandom;
      in_port_strb  = ($urandom_range(0, 99) < 45);
      out_port_strb = ($urandom_range(0, 99) < 50);
      out_port_data = $urandom;
      host_rd_ready = ($urandom_range(0, 99) < 40);
      err_clr       = ($urandom_range(0, 99) < 5);
      ready = (mq_in.size() < DEPTH); av = (mq_in.size() > 0);
      full = (mq_out.size() == DEPTH); nonempty = (mq_out.size() > 0);
`ifdef IO_PORT_STALL_EN
      if (!av) in_port_strb = 1'b0;
      if (full) out_port_strb = 1'b0;
`endif
      if (in_port_strb && av) void'(mq_in.pop_front());
      if (host_wr_valid && ready) mq_in.push_back(host_wr_data);
      if (host_rd_ready && nonempty) void'(mq_out.pop_front());
      if (out_port_strb && !full) mq_out.push_back(out_port_data);
`ifndef IO_PORT_STALL_EN
      if (in_port_strb && !av) m_ur = 1;
      if (out_port_strb && full) m_or = 1;
`endif
      if (err_clr) begin m_ur = 0; m_or = 0; end
      cycle();
      n_cmp++; if (host_wr_ready !== (mq_in.size() < DEPTH)) begin n_err++; $display("FAIL rnd_wr_ready c%0d: got %b want %b", c, host_wr_ready, mq_in.size() < DEPTH); end
      n_cmp++; if (in_port_data !== (mq_in.size() > 0 ? mq_in[0] : 32'h0)) begin n_err++; $display("FAIL rnd_in_data c%0d: got %h", c, in_port_data); end
      n_cmp++; if (host_rd_valid !== (mq_out.size() > 0)) begin n_err++; $display("FAIL rnd_rd_valid c%0d: got %b want %b", c, host_rd_valid, mq_out.size() > 0); end
      n_cmp++; if (host_rd_data !== (mq_out.size() > 0 ? mq_out[0] : 32'h0)) begin n_err++; $display("FAIL rnd_rd_data c%0d: got %h", c, host_rd_data); end
      n_cmp++; if ({err_underrun, err_overrun} !== {m_ur, m_or}) begin n_err++; $display("FAIL rnd_flags c%0d: got %b%b want %b%b", c, err_underrun, err_overrun, m_ur, m_or); end
      n_cmp++; if (stop_req !== 1'b0) begin n_err++; $display("FAIL rnd_stop c%0d: got %b want 0", c, stop_req); end
    end
    idle();
  endtask

  initial begin
    clr = 1'b1;
    idle();
    test_reset();
    test_reset_mid();
    test_order();
    test_boundary();
`ifdef IO_PORT_STALL_EN
    test_stall();
`else
    test_out_path();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
